mem_bus_arbiter: RTL

//  Shares the single native memory port (valid/ready, addr/wdata/wstrb/rdata) between the CPU core (M0) and the extension DMA/accelerator (M1).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_bus_arbiter_if.sv | 16 +
 rtl/mem_arb_watchdog.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, owner
// encoding and default parameter values. Contains no ports.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam int          TIMEOUT_DEFAULT  = 256;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory port bundle.
//   valid/instr/addr/wdata/wstrb : request, driven by the requester
//   ready/rdata                  : completion, driven by the responder
// modport master = the requesting side, modport slave = the responding side.
interface mem_bus_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arb_watchdog.sv
// Transfer watchdog counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : count one stalled cycle
//   terminal   : count has reached TIMEOUT_CYCLES-1
// The count saturates at the terminal value and never wraps.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic terminal
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign terminal = (count == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                count <= '0;
        else if (clr)              count <= '0;
        else if (en && !terminal)  count <= count + 1'b1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single native memory port.
//   clk, rst_n : clock, async active-low reset
//   m0, m1     : master ports (CPU core, DMA/accelerator)
//   mem        : port towards memory
//   grant      : one-hot owner {M1,M0}, 0 when idle
//   bus_err    : sticky watchdog-abort flag
//   err_clear  : synchronous clear of bus_err (a new abort wins)
// Grants alternate on completion; the owner keeps the bus until mem.ready or
// a watchdog abort. A master is never re-granted back-to-back, so a retained
// request sits out one idle cycle and the other master cannot starve.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_bus_if.slave   m0,
    mem_bus_if.slave   m1,
    mem_bus_if.master  mem,
    output logic [1:0] grant,
    output logic       bus_err,
    input  logic       err_clear
);
    arb_state_e  state, state_nxt;
    owner_e      last_owner, own;
    logic [1:0]  m_valid;
    logic        gnt_any, cur_valid, wd_term, abort, done;

    logic        mem_valid_o, mem_instr_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        rdy0, rdy1;
    logic [31:0] rd0, rd1;

    assign m_valid   = {m1.valid, m0.valid};
    assign gnt_any   = (state != ST_IDLE);
    assign own       = (state == ST_GNT1) ? OWN_M1 : OWN_M0;
    assign cur_valid = gnt_any && m_valid[own];
    // mem.ready on the terminal cycle still counts as a normal completion.
    assign abort     = cur_valid && wd_term && !mem.ready;
    assign done      = cur_valid && (mem.ready || wd_term);

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        // Restart on every grant change so each transfer gets a full budget.
        .clr      (!gnt_any || (state_nxt != state)),
        .en       (gnt_any && !mem.ready),
        .terminal (wd_term)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (m0.valid && m1.valid)
                    state_nxt = (last_owner == OWN_M1) ? ST_GNT0 : ST_GNT1;
                else if (m0.valid)
                    state_nxt = ST_GNT0;
                else if (m1.valid)
                    state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                if (!m0.valid)  state_nxt = ST_IDLE;
                else if (done)  state_nxt = m1.valid ? ST_GNT1 : ST_IDLE;
            end
            ST_GNT1: begin
                if (!m1.valid)  state_nxt = ST_IDLE;
                else if (done)  state_nxt = m0.valid ? ST_GNT0 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output muxes
    always_comb begin
        grant       = {state == ST_GNT1, state == ST_GNT0};
        mem_valid_o = 1'b0;
        mem_instr_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        rd0         = '0;
        rd1         = '0;
        case (state)
            ST_GNT0: begin
                mem_valid_o = m0.valid && !abort;
                mem_instr_o = m0.instr;
                mem_addr_o  = m0.addr;
                mem_wdata_o = m0.wdata;
                mem_wstrb_o = m0.wstrb;
                rdy0        = done;
                rd0         = abort ? ERR_DATA : mem.rdata;
            end
            ST_GNT1: begin
                mem_valid_o = m1.valid && !abort;
                mem_instr_o = m1.instr;
                mem_addr_o  = m1.addr;
                mem_wdata_o = m1.wdata;
                mem_wstrb_o = m1.wstrb;
                rdy1        = done;
                rd1         = abort ? ERR_DATA : mem.rdata;
            end
            default: ;
        endcase
    end

    assign mem.valid = mem_valid_o;
    assign mem.instr = mem_instr_o;
    assign mem.addr  = mem_addr_o;
    assign mem.wdata = mem_wdata_o;
    assign mem.wstrb = mem_wstrb_o;
    assign m0.ready  = rdy0;
    assign m0.rdata  = rd0;
    assign m1.ready  = rdy1;
    assign m1.rdata  = rd1;

    // Fairness pointer: only real completions (including aborts) move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_owner <= OWN_M1;
        else if (done)  last_owner <= own;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus_err <= 1'b0;
        else if (abort)      bus_err <= 1'b1;
        else if (err_clear)  bus_err <= 1'b0;
    end
endmodule
